// File: rtl/instruction_fetch_pkg.sv
// Types and constants shared by the instruction fetch unit and its skid FIFO.
// Optional feature macro used by the top: IF_MISALIGN_CHECK_EN.
`include "fetch_defs.v"

package instruction_fetch_pkg;

  localparam logic [31:0] IF_RESET_PC   = `FETCH_RESET_PC;
  localparam int          IF_INSTR_W    = `FETCH_INSTR_W;
  localparam int          IF_FIFO_DEPTH = `FETCH_FIFO_DEPTH;
  // Occupancy value at which the skid FIFO is full.
  localparam logic [1:0]  IF_FIFO_FULL  = 2'(IF_FIFO_DEPTH);

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [31:0]           pc;
    logic [IF_INSTR_W-1:0] instr;
  } fetch_word_t;

  // Round a byte address down to its containing 32-bit word.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_defs.v
// Shared fetch constants: reset PC default, instruction width, skid FIFO
// depth and the NOP encoding. Included by instruction_fetch_pkg.
`ifndef FETCH_DEFS_V
`define FETCH_DEFS_V

`define FETCH_RESET_PC   32'h0000_0000
`define FETCH_INSTR_W    32
`define FETCH_FIFO_DEPTH 2
`define FETCH_NOP        32'h0000_0013

`endif

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO of {pc, instr} words. Holds ROM responses that arrive
// while decode is stalled. Flush wins over push and pop in the same cycle.
module fetch_skid_fifo
  import instruction_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  fetch_word_t push_word,
  input  logic        pop,
  output logic [1:0]  count,
  output fetch_word_t head
);

  fetch_word_t mem [IF_FIFO_DEPTH];
  logic        rd_ptr;
  logic        wr_ptr;
  logic        do_push;
  logic        do_pop;

  // A pop on an empty FIFO is ignored; flush discards everything.
  assign do_pop  = pop && (count != 2'd0) && !flush;
  assign do_push = push && !flush;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      rd_ptr <= rd_ptr ^ do_pop;
      wr_ptr <= wr_ptr ^ do_push;
      count  <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  assign head = mem[rd_ptr];

  // The issue rule in the fetch unit guarantees room for every response;
  // a push into a full FIFO without a matching pop means that rule broke.
  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && (count == IF_FIFO_FULL)));

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, issues one ROM word request per cycle,
// presents words to decode with valid/ready, and restarts on redirect.
// Optional macro IF_MISALIGN_CHECK_EN: misaligned redirects raise a sticky
// fault and halt fetch; without it redirect targets are aligned down.
//
// Handshake: a word moves to decode on any cycle where if_valid and id_ready
// are both high. While if_valid is high and id_ready low, if_pc/if_instr are
// held. A redirect forces if_valid low, so id_ready has no effect that cycle.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [31:0]           imem_addr,
  output logic                  imem_en,
  input  logic [IF_INSTR_W-1:0] imem_dout,
  output logic                  if_valid,
  output logic [IF_INSTR_W-1:0] if_instr,
  output logic [31:0]           if_pc,
  input  logic                  id_ready,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  if_fault
);

  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;

  logic [1:0]  fifo_count;
  fetch_word_t fifo_head;
  fetch_word_t resp_word;
  logic        fifo_push;
  logic        fifo_pop;
  logic        transfer;
  logic [2:0]  occ_after;
  logic        issue_ok;
  logic [31:0] redirect_word;
  logic        misaligned;
  logic        halt;

  assign redirect_word = align_word(redirect_pc);

`ifdef IF_MISALIGN_CHECK_EN
  logic fault_q;

  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign halt       = fault_q;
  assign if_fault   = fault_q;

  // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (redirect) begin
      fault_q <= misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign halt       = 1'b0;
  assign if_fault   = 1'b0;
`endif

  // The ROM answers the request issued last cycle; tag it with its address.
  assign resp_word = '{pc: inflight_pc_q, instr: imem_dout};

  // Output select, FIFO control and request issue.
  always_comb begin
    if_valid  = 1'b0;
    if_instr  = '0;
    if_pc     = '0;
    imem_en   = 1'b0;
    imem_addr = pc_q;

    // Oldest word first: buffered words before the one arriving now.
    if (!rst && !redirect) begin
      if (fifo_count != 2'd0) begin
        if_valid = 1'b1;
        if_pc    = fifo_head.pc;
        if_instr = fifo_head.instr;
      end else if (inflight_q) begin
        if_valid = 1'b1;
        if_pc    = resp_word.pc;
        if_instr = resp_word.instr;
      end
    end

    transfer  = if_valid && id_ready;
    fifo_pop  = transfer && (fifo_count != 2'd0);
    // An arriving word is buffered unless it was bypassed straight to decode.
    fifo_push = inflight_q && !redirect && !(transfer && (fifo_count == 2'd0));

    // Words held or in flight after this cycle's pop must leave room for the
    // response to a request made now.
    occ_after = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
    issue_ok  = (occ_after < {1'b0, IF_FIFO_FULL});

    if (!rst) begin
      if (redirect) begin
        imem_addr = redirect_word;
        imem_en   = !misaligned;
      end else if (!halt && issue_ok) begin
        imem_en = 1'b1;
      end
    end
  end

  // PC and in-flight tracking; a redirect simply issues from its own target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (imem_en) begin
      pc_q          <= imem_addr + 32'd4;
      inflight_q    <= 1'b1;
      inflight_pc_q <= imem_addr;
    end else begin
      inflight_q    <= 1'b0;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (fifo_push),
    .push_word (resp_word),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by a randomized
// run checked against a stream model (the delivered words must be the
// consecutive addresses starting at the last redirect target or reset PC).
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_fault;

  int n_checks = 0;
  int n_errors = 0;

  // Clock.
  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_dout   (imem_dout),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_fault    (if_fault)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'hF000_0137;
      32'd4:   return 32'hFF01_0113;
      32'd8:   return 32'h0610_0193;
      32'd12:  return 32'h0031_2023;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Synchronous ROM, one-cycle latency, holds data while en is low.
  always @(posedge clk) begin
    if (imem_en) imem_dout <= rom_word(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, rom_word(pc));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit later.
  task automatic drive(input logic rdy, input logic rd, input logic [31:0] rp);
    @(negedge clk);
    rst         = 1'b0;
    id_ready    = rdy;
    redirect    = rd;
    redirect_pc = rp;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b1;
    redirect = 1'b0;
    id_ready = 1'b0;
    @(negedge clk);
    #1;
  endtask

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] exp_pc;
  logic [31:0] rp;
  logic        rdy;
  logic        rd;
  bit          active;
  bit          halted;

  initial begin
    // Reset values and straight-line fetch.
    apply_reset();
    chk("rst_en", {31'd0, imem_en}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_fault", {31'd0, if_fault}, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    chk("c0_en", {31'd0, imem_en}, 32'd1);
    chk("c0_addr", imem_addr, 32'd0);
    chk("c0_valid", {31'd0, if_valid}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 32'd0);
      chk_word("stream", 32'(4 * (k - 1)));
    end

    // Decode stall: two words buffered, requests stop, drain without gaps.
    apply_reset();
    drive(1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    chk_word("stall_c1", 32'd0);
    for (int k = 2; k <= 6; k++) begin
      drive(1'b0, 1'b0, 32'd0);
      chk_word("stall_hold", 32'd4);
      if (k >= 4) chk("stall_en", {31'd0, imem_en}, 32'd0);
    end
    drive(1'b1, 1'b0, 32'd0);
    chk_word("drain_0", 32'd4);
    chk("drain_en", {31'd0, imem_en}, 32'd1);
    drive(1'b1, 1'b0, 32'd0);
    chk_word("drain_1", 32'd8);
    drive(1'b1, 1'b0, 32'd0);
    chk_word("drain_2", 32'd12);
    drive(1'b1, 1'b0, 32'd0);
    chk_word("drain_3", 32'd16);

    // Redirect with one word buffered and one in flight.
    apply_reset();
    drive(1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    chk_word("pre_redir", 32'd0);
    drive(1'b0, 1'b1, 32'd8);
    chk("redir_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_en", {31'd0, imem_en}, 32'd1);
    chk("redir_addr", imem_addr, 32'd8);
    drive(1'b1, 1'b0, 32'd0);
    chk_word("redir_w0", 32'd8);
    drive(1'b1, 1'b0, 32'd0);
    chk_word("redir_w1", 32'd12);

    // Redirect together with id_ready: presented word is not consumed.
    drive(1'b1, 1'b1, 32'd0);
    chk("redir_rdy_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_rdy_addr", imem_addr, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    chk_word("redir_rdy_w0", 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    chk_word("redir_rdy_w1", 32'd4);

    // Asynchronous reset while the FIFO is full.
    apply_reset();
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 32'd0);
    chk_word("full_head", 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_en", {31'd0, imem_en}, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_instr", if_instr, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    chk("arst_c0_en", {31'd0, imem_en}, 32'd1);
    chk("arst_c0_valid", {31'd0, if_valid}, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    chk_word("arst_refetch", 32'd0);

    // Misaligned redirect.
`ifdef IF_MISALIGN_CHECK_EN
    drive(1'b1, 1'b1, 32'd6);
    chk("mis_en", {31'd0, imem_en}, 32'd0);
    chk("mis_valid", {31'd0, if_valid}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 32'd0);
      chk("mis_fault", {31'd0, if_fault}, 32'd1);
      chk("mis_halt_en", {31'd0, imem_en}, 32'd0);
      chk("mis_halt_valid", {31'd0, if_valid}, 32'd0);
    end
    drive(1'b1, 1'b1, 32'd12);
    chk("fix_en", {31'd0, imem_en}, 32'd1);
    chk("fix_addr", imem_addr, 32'd12);
    drive(1'b1, 1'b0, 32'd0);
    chk("fix_fault", {31'd0, if_fault}, 32'd0);
    chk_word("fix_word", 32'd12);
`else
    drive(1'b1, 1'b1, 32'd6);
    chk("mis_en", {31'd0, imem_en}, 32'd1);
    chk("mis_addr", imem_addr, 32'd4);
    drive(1'b1, 1'b0, 32'd0);
    chk("mis_fault", {31'd0, if_fault}, 32'd0);
    chk_word("mis_word", 32'd4);
`endif

    // Randomized run against the stream model.
    apply_reset();
    exp_pc = 32'd0;
    active = 1'b0;
    halted = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 11) == 0);
      rp  = 32'($urandom_range(0, 5) * 4);
      if ($urandom_range(0, 3) == 0) rp = rp + 32'($urandom_range(1, 3));
      drive(rdy, rd, rp);
      if (rd) begin
        chk("rnd_redir_valid", {31'd0, if_valid}, 32'd0);
`ifdef IF_MISALIGN_CHECK_EN
        if (rp[1:0] != 2'b00) begin
          halted = 1'b1;
          chk("rnd_mis_en", {31'd0, imem_en}, 32'd0);
        end else begin
          halted = 1'b0;
          exp_pc = rp;
          chk("rnd_redir_en", {31'd0, imem_en}, 32'd1);
          chk("rnd_redir_addr", imem_addr, exp_pc);
        end
`else
        exp_pc = {rp[31:2], 2'b00};
        chk("rnd_redir_en", {31'd0, imem_en}, 32'd1);
        chk("rnd_redir_addr", imem_addr, exp_pc);
`endif
      end else begin
        chk("rnd_valid", {31'd0, if_valid}, {31'd0, active && !halted});
        if (active && !halted) begin
          chk("rnd_pc", if_pc, exp_pc);
          chk("rnd_instr", if_instr, rom_word(exp_pc));
          if (rdy) exp_pc = exp_pc + 32'd4;
        end
        chk("rnd_fault", {31'd0, if_fault}, {31'd0, halted});
      end
      active = !halted;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
